shift_word_loader: RTL and testbench
====================================

# shift_word_loader

Parallel-to-serial loader that sits directly upstream of the team's 4-bit bidirectional shift register. It accepts a parallel word and a direction over a valid/ready handshake. It then drives the register's shift_left / shift_right / data_in controls for exactly WIDTH single-cycle shift pulses, so the register ends up holding the word. Finally it reads the register contents back and reports them with a one-cycle completion pulse.

## Interface
- WIDTH, 4: bits per word; must equal the downstream register width (minimum 2).
- GAP, 0: idle cycles inserted between consecutive shift pulses (0 to 15).

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  loader idle; a request is accepted when in_valid and in_ready are both high on a rising edge.
- in_data  input  WIDTH  word to load; sampled only on accept.
- in_dir  input  1  shift direction: 0 = left, 1 = right; sampled only on accept.
- shift_left  output  1  left-shift control to the register.
- shift_right  output  1  right-shift control to the register.
- data_in  output  1  serial bit to the register.
- reg_q  input  WIDTH  the register's data_out, used for readback.
- busy  output  1  high in any state other than IDLE.
- done_valid  output  1  one-cycle pulse when a load completes.
- done_data  output  WIDTH  reg_q captured at completion; holds its value until the next completion.
- mismatch  output  1  readback compare result; valid while done_valid is high.

## Operation
- FSM states are IDLE, SHIFT, GAP and CHECK. Outputs are Moore decodes of registered state plus datapath registers.
- **IDLE**
  - in_ready=1; shift_left, shift_right and data_in are 0.
  - On accept: latch in_data and in_dir, clear the bit counter, go to SHIFT.
- **SHIFT**
  - Exactly one of shift_left/shift_right is high: shift_left if dir=0, shift_right if dir=1.
  - data_in carries the current bit. Order: left sends MSB first (bit WIDTH-1 down to 0); right sends LSB first (bit 0 up to WIDTH-1). Either way the register equals in_data after the final pulse.
  - Counter increments each SHIFT cycle.
  - After the shift with count WIDTH-1, go to CHECK.
  - Otherwise go to GAP if GAP>0, else stay in SHIFT.
- **GAP**
  - All shift controls are 0; count GAP cycles, then return to SHIFT.
- **CHECK**
  - One cycle. On its closing edge: done_data <= reg_q, done_valid <= 1 for one cycle, state -> IDLE.
- **Rules**
  - shift_left and shift_right are never high together.
  - Exactly WIDTH shift pulses are issued per accepted word.
  - in_valid while busy is ignored and does not stall; in_ready is simply low.
  - A new request may be accepted in the same cycle done_valid is high, since the FSM is already in IDLE.
  - Counter width is clog2(WIDTH)+1 bits; the GAP counter is 4 bits.

## Timing
- **Reset:**
  - Outputs while reset is asserted: state IDLE, in_ready=1, busy=0, shift_left=0, shift_right=0, data_in=0, done_valid=0, done_data=0, mismatch=0.
  - Reset mid-operation aborts the load immediately. No further shift pulses are issued and no done_valid is produced. The register's own reset clears it separately.
- **Accept at edge t0:**
  - Shift pulses occur in cycles t0+1+k·(GAP+1), for k=0..WIDTH-1.
  - CHECK is the cycle after the last pulse; done_valid is high in the following cycle.
- **Latency** from accept edge to done_valid cycle: WIDTH+2+(WIDTH-1)·GAP. With WIDTH=4, GAP=0 this is 6 cycles.
- **Throughput (GAP=0):** one word per WIDTH+2 cycles.

## Configuration
- **SHIFT_WORD_LOADER_VERIFY_EN**
  - Defined: in CHECK, compare reg_q against the latched word. mismatch registers the inequality alongside done_valid and holds until the next completion.
  - Undefined: the compare logic is absent and mismatch is tied to 0. The port list is identical either way.

## Test plan
- Reset, then in_data=4'b1011, dir=0, GAP=0, with a behavioural register model. Required: shift_left high 4 consecutive cycles, data_in sequence 1,0,1,1, done_valid 6 cycles after accept, done_data=4'b1011, mismatch=0.
- in_data=4'b1011, dir=1. Required: shift_right pulses carrying data_in 1,1,0,1; done_data=4'b1011.
- GAP=2, in_data=4'b0110, dir=0. Required: pulses spaced 3 cycles apart, done_valid 12 cycles after accept, done_data=4'b0110.
- Hold in_valid high continuously with alternating words. Required: in_ready low during each load; each word is accepted on its done_valid cycle; no shift pulse overlap; no word lost or duplicated.
- Assert reset after the second shift pulse. Required: all shift controls drop to 0 asynchronously, in_ready=1, no done_valid; a subsequent word loads correctly.
- With SHIFT_WORD_LOADER_VERIFY_EN defined, the model corrupts reg_q to 4'b0000 during CHECK. Required: done_data=4'b0000, mismatch=1 with done_valid. With the macro undefined, mismatch stays 0.

Source files
------------

// File: rtl/shift_word_loader_if.sv
// Request and shift-register link between a word source, the loader and the 4-bit shift register.
// No latency (wires only); backpressure is in_ready, driven by the loader.
interface shift_word_loader_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             shift_left;
    logic             shift_right;
    logic             data_in;
    logic [WIDTH-1:0] reg_q;
    logic             busy;
    logic             done_valid;
    logic [WIDTH-1:0] done_data;
    logic             mismatch;

    modport master (
        output in_valid, in_data, in_dir, reg_q,
        input  in_ready, shift_left, shift_right, data_in, busy, done_valid, done_data, mismatch
    );

    modport slave (
        input  in_valid, in_data, in_dir, reg_q,
        output in_ready, shift_left, shift_right, data_in, busy, done_valid, done_data, mismatch
    );
endinterface

// File: rtl/shift_word_loader.sv
// Parallel-to-serial loader driving a bidirectional shift register, with readback; SHIFT_WORD_LOADER_VERIFY_EN adds the readback compare.
// Latency WIDTH+2+(WIDTH-1)*GAP cycles from accept to done_valid; in_ready is high only in IDLE, requests while busy are ignored.
module shift_word_loader #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic                clk,
    input  logic                reset,
    shift_word_loader_if.slave  bus
);
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_dir;
    logic             r_done_valid;
    logic [WIDTH-1:0] r_done_data;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_busy;
    logic             w_shift_left;
    logic             w_shift_right;
    logic             w_data_in;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == LAST_BIT) w_next = S_CHECK;
                else if (GAP > 0)      w_next = S_GAP;
                else                   w_next = S_SHIFT;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next = S_SHIFT;
            end
            S_CHECK: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The shift copy always presents the next bit at its MSB (left) or LSB (right).
    always_comb begin
        w_in_ready    = (r_state == S_IDLE);
        w_busy        = (r_state != S_IDLE);
        w_shift_left  = (r_state == S_SHIFT) && !r_dir;
        w_shift_right = (r_state == S_SHIFT) &&  r_dir;
        w_data_in     = (r_state == S_SHIFT) && (r_dir ? r_shreg[0] : r_shreg[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_shreg      <= '0;
            r_dir        <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_data  <= '0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= bus.in_data;
                        r_dir   <= bus.in_dir;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_cnt     <= r_cnt + 1'b1;
                    r_gap_cnt <= '0;
                    r_shreg   <= r_dir ? (r_shreg >> 1) : (r_shreg << 1);
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                S_CHECK: begin
                    r_done_valid <= 1'b1;
                    r_done_data  <= bus.reg_q;
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_WORD_LOADER_VERIFY_EN
    logic [WIDTH-1:0] r_word;
    logic             r_mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word     <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_accept)            r_word     <= bus.in_data;
            if (r_state == S_CHECK)  r_mismatch <= (bus.reg_q != r_word);
        end
    end

    assign bus.mismatch = r_mismatch;
`else
    assign bus.mismatch = 1'b0;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.busy        = w_busy;
    assign bus.shift_left  = w_shift_left;
    assign bus.shift_right = w_shift_right;
    assign bus.data_in     = w_data_in;
    assign bus.done_valid  = r_done_valid;
    assign bus.done_data   = r_done_data;
endmodule

// File: tb/tb_shift_word_loader.sv
// Bench for shift_word_loader: two instances (GAP=0 and GAP=2), each feeding a behavioural 4-bit shift register.
// Directed vectors from a table plus back-to-back, reset-abort and readback-corruption sequences.
module tb_shift_word_loader;
    logic clk;
    logic reset;
    logic corrupt;
    logic sel;
    logic [3:0] q0, q1;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef SHIFT_WORD_LOADER_VERIFY_EN
    localparam logic EXP_CORRUPT_MM = 1'b1;
`else
    localparam logic EXP_CORRUPT_MM = 1'b0;
`endif

    shift_word_loader_if #(.WIDTH(4)) bus0 ();
    shift_word_loader_if #(.WIDTH(4)) bus1 ();

    shift_word_loader #(.WIDTH(4), .GAP(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    shift_word_loader #(.WIDTH(4), .GAP(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) q0 <= 4'b0000;
        else if (bus0.shift_left)  q0 <= {q0[2:0], bus0.data_in};
        else if (bus0.shift_right) q0 <= {bus0.data_in, q0[3:1]};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) q1 <= 4'b0000;
        else if (bus1.shift_left)  q1 <= {q1[2:0], bus1.data_in};
        else if (bus1.shift_right) q1 <= {bus1.data_in, q1[3:1]};
    end

    assign bus0.reg_q = (corrupt && !sel) ? 4'b0000 : q0;
    assign bus1.reg_q = (corrupt &&  sel) ? 4'b0000 : q1;

    logic s_rdy, s_busy, s_shl, s_shr, s_din, s_done, s_mm;
    logic [3:0] s_dd;
    always_comb begin
        if (!sel) begin
            s_rdy = bus0.in_ready; s_busy = bus0.busy; s_shl = bus0.shift_left; s_shr = bus0.shift_right;
            s_din = bus0.data_in;  s_done = bus0.done_valid; s_mm = bus0.mismatch; s_dd = bus0.done_data;
        end else begin
            s_rdy = bus1.in_ready; s_busy = bus1.busy; s_shl = bus1.shift_left; s_shr = bus1.shift_right;
            s_din = bus1.data_in;  s_done = bus1.done_valid; s_mm = bus1.mismatch; s_dd = bus1.done_data;
        end
    end

    typedef struct {
        logic       sel;
        logic [3:0] word;
        logic       dir;
        logic       corrupt;
        logic [3:0] exp_seq;    // data_in bits in pulse order, first pulse in the MSB
        int         exp_lat;
        int         exp_space;
        logic [3:0] exp_dd;
        logic       exp_mm;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic s, input logic v, input logic [3:0] d, input logic dir);
        if (!s) begin bus0.in_valid = v; bus0.in_data = d; bus0.in_dir = dir; end
        else    begin bus1.in_valid = v; bus1.in_data = d; bus1.in_dir = dir; end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c, npulse, pos_bad, ctl_bad, rdy_bad, lat;
        logic [3:0] seq, dd;
        logic mm, got, rdy_done;
        c = 1; npulse = 0; pos_bad = 0; ctl_bad = 0; rdy_bad = 0; lat = -1;
        seq = 4'b0; dd = 4'b0; mm = 1'b0; got = 1'b0; rdy_done = 1'b0;
        sel = v.sel;
        corrupt = v.corrupt;
        @(negedge clk);
        check("ready_idle", idx, 32'(s_rdy), 32'd1);
        drive(v.sel, 1'b1, v.word, v.dir);
        @(posedge clk);
        @(negedge clk);
        drive(v.sel, 1'b0, 4'b0000, 1'b0);
        while (!got && c <= 40) begin
            if (s_shl && s_shr) ctl_bad++;
            if (s_shl || s_shr) begin
                if (s_shr != v.dir) ctl_bad++;
                if (c != 1 + npulse * v.exp_space) pos_bad++;
                seq = {seq[2:0], s_din};
                npulse++;
            end else if (s_din) begin
                ctl_bad++;
            end
            if (s_done) begin
                got = 1'b1; lat = c; dd = s_dd; mm = s_mm; rdy_done = s_rdy;
            end else begin
                if (s_rdy) rdy_bad++;
                @(negedge clk);
                c++;
            end
        end
        corrupt = 1'b0;
        check("done_seen",    idx, 32'(got),      32'd1);
        check("latency",      idx, 32'(lat),      32'(v.exp_lat));
        check("pulse_count",  idx, 32'(npulse),   32'd4);
        check("data_in_seq",  idx, 32'(seq),      32'(v.exp_seq));
        check("pulse_pos",    idx, 32'(pos_bad),  32'd0);
        check("shift_ctl",    idx, 32'(ctl_bad),  32'd0);
        check("ready_busy",   idx, 32'(rdy_bad),  32'd0);
        check("ready_done",   idx, 32'(rdy_done), 32'd1);
        check("done_data",    idx, 32'(dd),       32'(v.exp_dd));
        check("mismatch",     idx, 32'(mm),       32'(v.exp_mm));
    endtask

    vec_t vecs[6];
    vec_t vr;

    initial begin
        logic [3:0] acc_q[4];
        int n_acc, n_done, np, ovl, dbad, abad, sbad, last_done, idle_bad;
        logic pend;

        vecs[0] = '{1'b0, 4'b1011, 1'b0, 1'b0, 4'b1011, 6,  1, 4'b1011, 1'b0};
        vecs[1] = '{1'b0, 4'b1011, 1'b1, 1'b0, 4'b1101, 6,  1, 4'b1011, 1'b0};
        vecs[2] = '{1'b1, 4'b0110, 1'b0, 1'b0, 4'b0110, 12, 3, 4'b0110, 1'b0};
        vecs[3] = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b1000, 6,  1, 4'b0001, 1'b0};
        vecs[4] = '{1'b1, 4'b1001, 1'b1, 1'b0, 4'b1001, 12, 3, 4'b1001, 1'b0};
        vecs[5] = '{1'b0, 4'b1011, 1'b0, 1'b1, 4'b1011, 6,  1, 4'b0000, EXP_CORRUPT_MM};

        reset = 1'b1; corrupt = 1'b0; sel = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        check("reset_outs", 0, 32'({s_rdy, s_busy, s_shl, s_shr, s_din, s_done, s_mm, s_dd}), 32'h400);
        sel = 1'b1;
        #1;
        check("reset_outs", 1, 32'({s_rdy, s_busy, s_shl, s_shr, s_din, s_done, s_mm, s_dd}), 32'h400);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Back-to-back: in_valid held high, word toggles after each accept.
        sel = 1'b0;
        n_acc = 0; n_done = 0; np = 0; ovl = 0; dbad = 0; abad = 0; sbad = 0; last_done = 0; pend = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1010, 1'b0);
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (s_shl && s_shr) ovl++;
            if (s_shl || s_shr) np++;
            if (s_done) begin
                if (n_done < n_acc) begin
                    if (s_dd !== acc_q[n_done]) dbad++;
                end else begin
                    dbad++;
                end
                if (n_done > 0 && cyc - last_done != 6) sbad++;
                last_done = cyc;
                n_done++;
            end
            if (bus0.in_valid && s_rdy) begin
                if (n_acc > 0 && !s_done) abad++;
                if (n_acc < 4) acc_q[n_acc] = bus0.in_data;
                n_acc++;
                pend = 1'b1;
            end
            if (n_done == 3) break;
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                bus0.in_data = ~bus0.in_data;
                if (n_acc == 3) bus0.in_valid = 1'b0;
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        check("b2b_accepts", 0, 32'(n_acc), 32'd3);
        check("b2b_dones",   0, 32'(n_done), 32'd3);
        check("b2b_pulses",  0, 32'(np),    32'd12);
        check("b2b_overlap", 0, 32'(ovl),   32'd0);
        check("b2b_data",    0, 32'(dbad),  32'd0);
        check("b2b_accept_timing", 0, 32'(abad), 32'd0);
        check("b2b_throughput",    0, 32'(sbad), 32'd0);
        check("b2b_word1", 0, 32'(acc_q[1]), 32'h5);

        // Reset during the third pulse of a load.
        sel = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_abort_pulse", 0, 32'({s_shl, s_din}), 32'h3);
        #1;
        reset = 1'b1;
        #1;
        check("abort_outs", 0, 32'({s_rdy, s_busy, s_shl, s_shr, s_din}), 32'h10);
        @(negedge clk);
        reset = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_done || s_shl || s_shr || !s_rdy) idle_bad++;
        end
        check("abort_quiet", 0, 32'(idle_bad), 32'd0);
        vr = '{1'b0, 4'b0110, 1'b1, 1'b0, 4'b0110, 6, 1, 4'b0110, 1'b0};
        run_vec(vr, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
